time_display_driver: RTL and testbench

//  Consumes the min/sec/10ms binary counts from the stopwatch counter core and drives a
//  6-digit multiplexed 7-segment display as MM.SS.CC. Periodically snapshots the counts with
//  a coherence check, converts each field to BCD with a sequential shift-add-3 FSM, and

---
 rtl/time_display_driver.sv | 207 ++++++++++++++++++++
 tb/tb_time_display_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_display_driver.sv
// ============================================================================
// Module   : time_display_driver
// Brief    : Snapshots stopwatch MM/SS/CC counts, converts them to BCD and
//            scans them onto a 6-digit multiplexed 7-segment display.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module time_display_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int SAMPLE_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic [6:0] ms_10_i,
  input  logic       hold_i,
  output logic [7:0] seg_o,
  output logic [5:0] an_o,
  output logic       busy_o,
  output logic       upd_o
);

  localparam int c_scan_w   = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int c_sample_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [c_scan_w-1:0]   c_scan_last   = c_scan_w'(SCAN_DIV - 1);
  localparam logic [c_sample_w-1:0] c_sample_last = c_sample_w'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAP1 = 3'd1,
    S_CAP2 = 3'd2,
    S_CONV = 3'd3,
    S_UPD  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [c_scan_w-1:0]     r_scan_cnt;
  logic [c_sample_w-1:0]   r_sample_cnt;
  logic [2:0]              r_digit;
  logic [18:0]             r_snap;
  logic [1:0]              r_retry;
  logic [1:0]              r_field;
  logic [2:0]              r_iter;
  logic [6:0]              r_bin;
  logic [7:0]              r_bcd;
  logic [2:0]              r_dash;
  logic [23:0]             r_shadow;
  logic [23:0]             r_disp;

  logic                    w_tick;
  logic                    w_scan_wrap;
  logic [2:0]              w_digit_nxt;
  logic [18:0]             w_live;
  logic [7:0]              w_adj;
  logic [14:0]             w_shift;
  logic [7:0]              w_bcd_nxt;
  logic [6:0]              w_bin_nxt;
  logic [23:0]             w_disp_nxt;
  logic [3:0]              w_digit_val;
  logic                    w_dp;

  // Active-low {g,f,e,d,c,b,a}; any non-decimal code is the dash marker.
  function automatic logic [6:0] f_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign w_tick      = (r_sample_cnt == c_sample_last);
  assign w_scan_wrap = (r_scan_cnt == c_scan_last);
  assign w_digit_nxt = !w_scan_wrap      ? r_digit :
                       (r_digit == 3'd5) ? 3'd0    : r_digit + 3'd1;
  assign w_live      = {min_i, sec_i, ms_10_i};

  // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
  assign w_adj[3:0]  = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
  assign w_adj[7:4]  = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
  assign w_shift     = {w_adj, r_bin} << 1;
  assign w_bcd_nxt   = w_shift[14:7];
  assign w_bin_nxt   = w_shift[6:0];

  // Segments are registered alongside upd_o, so look through to the shadow in UPD.
  assign w_disp_nxt  = (r_state == S_UPD) ? r_shadow : r_disp;
  assign w_digit_val = w_disp_nxt[{w_digit_nxt, 2'b00} +: 4];
  assign w_dp        = (w_digit_nxt == 3'd2) || (w_digit_nxt == 3'd4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_cnt <= '0;
    end else if (w_tick) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_digit    <= 3'd0;
      an_o       <= 6'h3F;
      seg_o      <= 8'hFF;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
      r_digit    <= w_digit_nxt;
      an_o       <= ~(6'b000001 << w_digit_nxt);
      seg_o      <= {~w_dp, f_seg(w_digit_val)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_snap   <= '0;
      r_retry  <= 2'd0;
      r_field  <= 2'd0;
      r_iter   <= 3'd0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_dash   <= '0;
      r_shadow <= '0;
      r_disp   <= '0;
      busy_o   <= 1'b0;
      upd_o    <= 1'b0;
    end else begin
      upd_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick && !hold_i) begin
            r_state <= S_CAP1;
            r_retry <= 2'd0;
            busy_o  <= 1'b1;
          end
        end
        S_CAP1: begin
          r_snap  <= w_live;
          r_state <= S_CAP2;
        end
        S_CAP2: begin
          // The counter core runs on another clock: accept only a repeatable sample.
          if (w_live == r_snap) begin
            r_state <= S_CONV;
            r_bin   <= r_snap[6:0];
            r_bcd   <= '0;
            r_iter  <= 3'd0;
            r_field <= 2'd0;
            r_dash  <= {r_snap[18:13] > 6'd59, r_snap[12:7] > 6'd59, r_snap[6:0] > 7'd99};
          end else if (r_retry == 2'd2) begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
          end else begin
            r_retry <= r_retry + 2'd1;
            r_state <= S_CAP1;
          end
        end
        S_CONV: begin
          if (r_iter == 3'd6) begin
            r_shadow[{r_field, 3'b000} +: 8] <= r_dash[r_field] ? 8'hFF : w_bcd_nxt;
            r_bcd  <= '0;
            r_iter <= 3'd0;
            case (r_field)
              2'd0:    r_bin <= {1'b0, r_snap[12:7]};
              2'd1:    r_bin <= {1'b0, r_snap[18:13]};
              default: r_bin <= '0;
            endcase
            if (r_field == 2'd2) begin
              r_state <= S_UPD;
            end else begin
              r_field <= r_field + 2'd1;
            end
          end else begin
            r_bcd  <= w_bcd_nxt;
            r_bin  <= w_bin_nxt;
            r_iter <= r_iter + 3'd1;
          end
        end
        S_UPD: begin
          r_disp  <= r_shadow;
          upd_o   <= 1'b1;
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_time_display_driver.sv
// ============================================================================
// Module   : tb_time_display_driver
// Brief    : Self-checking bench for time_display_driver (table, random, corners).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_time_display_driver;

  localparam int SCAN_DIV   = 4;
  localparam int SAMPLE_DIV = 64;

  logic       clk;
  logic       rst;
  logic [5:0] min_i;
  logic [5:0] sec_i;
  logic [6:0] ms_10_i;
  logic       hold_i;
  logic [7:0] seg_o;
  logic [5:0] an_o;
  logic       busy_o;
  logic       upd_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int upd_total  = 0;
  int busy_total = 0;

  typedef struct {
    logic [5:0]  m;
    logic [5:0]  s;
    logic [6:0]  c;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [6];

  time_display_driver #(
    .SCAN_DIV   (SCAN_DIV),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .min_i   (min_i),
    .sec_i   (sec_i),
    .ms_10_i (ms_10_i),
    .hold_i  (hold_i),
    .seg_o   (seg_o),
    .an_o    (an_o),
    .busy_o  (busy_o),
    .upd_o   (upd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (upd_o === 1'b1)  upd_total  <= upd_total + 1;
      if (busy_o === 1'b1) busy_total <= busy_total + 1;
    end
  end

  // Expected digit codes {MM,SS,CC}; 4'hF marks a dashed digit.
  function automatic logic [7:0] field_code(input int v, input int maxv);
    if (v > maxv) return 8'hFF;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] model(input int m, input int s, input int c);
    return {field_code(m, 59), field_code(s, 59), field_code(c, 99)};
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] v, input int d);
    logic [7:0] r;
    case (v)
      4'd0: r = 8'hC0;  4'd1: r = 8'hF9;  4'd2: r = 8'hA4;  4'd3: r = 8'hB0;
      4'd4: r = 8'h99;  4'd5: r = 8'h92;  4'd6: r = 8'h82;  4'd7: r = 8'hF8;
      4'd8: r = 8'h80;  4'd9: r = 8'h90;
      default: r = 8'hBF;
    endcase
    if (d == 2 || d == 4) r[7] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_tick(output int t);
    do @(negedge clk); while ((cyc % SAMPLE_DIV) != SAMPLE_DIV - 1);
    t = cyc;
  endtask

  task automatic wait_upd(input int t, input int lat, input string name);
    int start;
    int u;
    int busy_n;
    start  = cyc;
    u      = -1;
    busy_n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (upd_o === 1'b1) begin
        u = cyc;
        break;
      end
      if (busy_o === 1'b1) busy_n++;
    end
    chk({name, "_lat"}, u - t, lat);
    chk({name, "_busy"}, busy_n, t + lat - 1 - start);
    @(negedge clk);
    chk({name, "_pulse"}, int'(upd_o), 0);
  endtask

  task automatic check_display(input logic [23:0] exp, input string name);
    int d;
    logic [5:0] ea;
    logic [3:0] dv;
    for (int i = 0; i < 6 * SCAN_DIV; i++) begin
      @(negedge clk);
      d  = (cyc / SCAN_DIV) % 6;
      ea = ~(6'b000001 << d);
      dv = exp[4*d +: 4];
      chk({name, "_an"}, int'(an_o), int'(ea));
      chk({name, "_seg"}, int'(seg_o), int'(seg_code(dv, d)));
    end
  endtask

  task automatic set_in(input int m, input int s, input int c);
    min_i   = 6'(m);
    sec_i   = 6'(s);
    ms_10_i = 7'(c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int u0;
    int b0;
    int m;
    int s;
    int c;

    tbl[0] = '{m: 6'd12, s: 6'd34, c: 7'd56,  exp: 24'h123456};
    tbl[1] = '{m: 6'd5,  s: 6'd60, c: 7'd7,   exp: 24'h05FF07};
    tbl[2] = '{m: 6'd0,  s: 6'd0,  c: 7'd127, exp: 24'h0000FF};
    tbl[3] = '{m: 6'd59, s: 6'd59, c: 7'd99,  exp: 24'h595999};
    tbl[4] = '{m: 6'd63, s: 6'd0,  c: 7'd0,   exp: 24'hFF0000};
    tbl[5] = '{m: 6'd9,  s: 6'd10, c: 7'd1,   exp: 24'h091001};

    rst    = 1'b0;
    hold_i = 1'b0;
    set_in(0, 0, 0);
    #23;
    chk("rst_seg",  int'(seg_o),  8'hFF);
    chk("rst_an",   int'(an_o),   6'h3F);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_upd",  int'(upd_o),  0);

    @(negedge clk);
    rst = 1'b1;
    check_display(24'h000000, "scan0");

    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].m, tbl[i].s, tbl[i].c);
      wait_tick(t);
      wait_upd(t, 25, $sformatf("vec%0d", i));
      check_display(tbl[i].exp, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      m = $urandom_range(0, 63);
      s = $urandom_range(0, 63);
      c = $urandom_range(0, 127);
      set_in(m, s, c);
      wait_tick(t);
      wait_upd(t, 25, $sformatf("rnd%0d", i));
      check_display(model(m, s, c), $sformatf("rnd%0d", i));
    end

    // One incoherent sample: ms_10 changes while the snapshot is being verified.
    set_in(11, 22, 33);
    wait_tick(t);
    go_to(t + 2);
    ms_10_i = 7'd44;
    wait_upd(t, 27, "retry1");
    check_display(24'h112244, "retry1");

    // Three incoherent samples in a row abandon the update.
    wait_tick(t);
    u0 = upd_total;
    go_to(t + 2);
    ms_10_i = 7'd1;
    go_to(t + 4);
    ms_10_i = 7'd2;
    go_to(t + 6);
    ms_10_i = 7'd3;
    go_to(t + 8);
    chk("retry3_busy", int'(busy_o), 0);
    check_display(24'h112244, "retry3");
    go_to(t + 40);
    chk("retry3_noupd", upd_total - u0, 0);

    hold_i = 1'b1;
    set_in(33, 44, 55);
    u0 = upd_total;
    b0 = busy_total;
    for (int k = 0; k < 3; k++) wait_tick(t);
    go_to(t + 30);
    chk("hold_noupd", upd_total - u0, 0);
    chk("hold_nobusy", busy_total - b0, 0);
    check_display(24'h112244, "hold");

    // Hold asserted mid-conversion must not abort it.
    hold_i = 1'b0;
    wait_tick(t);
    go_to(t + 10);
    hold_i = 1'b1;
    wait_upd(t, 25, "holdmid");
    check_display(24'h334455, "holdmid");
    hold_i = 1'b0;

    set_in(7, 8, 9);
    wait_tick(t);
    go_to(t + 10);
    rst = 1'b0;
    #1;
    chk("rstmid_seg",  int'(seg_o),  8'hFF);
    chk("rstmid_an",   int'(an_o),   6'h3F);
    chk("rstmid_busy", int'(busy_o), 0);
    chk("rstmid_upd",  int'(upd_o),  0);
    @(negedge clk);
    rst = 1'b1;
    check_display(24'h000000, "rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
